// File: rtl/audio_nios_pkg.sv
// Shared definitions for the audio sample writer: data width, byte lanes, FSM encoding.
package audio_nios_pkg;

  localparam int unsigned DataW = 32;
  localparam logic [3:0]  ByteEnAll = 4'hF;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } state_e;

endpackage

// File: rtl/audio_nios_sample_fifo.sv
// Synchronous sample FIFO; Depth must be a power of two so the pointers wrap naturally.
module audio_nios_sample_fifo
  import audio_nios_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [DataW-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [DataW-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth):0]     count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [DataW-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [PtrW:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  // Overflowing pushes and underflowing pops are dropped.
  always_comb begin
    push_ok = push_i && !full_o;
    pop_ok  = pop_i && !empty_o;
    wr_d    = push_ok ? wr_q + PtrW'(1) : wr_q;
    rd_d    = pop_ok ? rd_q + PtrW'(1) : rd_q;
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + (PtrW + 1)'(1);
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - (PtrW + 1)'(1);
    end
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_q] <= wdata_i;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_q];
  assign full_o  = (count_q == (PtrW + 1)'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/audio_nios_sample_writer.sv
// Captures an Avalon-ST audio stream into a ring buffer in on-chip memory.
module audio_nios_sample_writer
  import audio_nios_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 51200,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DataW-1:0]  snk_data,
  input  logic              snk_valid,
  output logic              snk_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DataW-1:0]  mem_writedata,
  output logic              mem_clken,
  input  logic              mem_grant,
  output logic              irq_half,
  output logic              irq_full,
  output logic              overrun,
  input  logic              irq_clear,
  output logic [ADDR_W-1:0] wr_ptr
);

  localparam int unsigned       CntW     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(DEPTH_WORDS - 1);
  localparam logic [ADDR_W-1:0] HalfIdx  = ADDR_W'(DEPTH_WORDS / 2 - 1);
  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic              irq_half_q, irq_half_d;
  logic              irq_full_q, irq_full_d;
  logic              overrun_q, overrun_d;

  logic              fifo_full, fifo_empty;
  logic [CntW-1:0]   fifo_count;
  logic [DataW-1:0]  fifo_rdata;
  logic              push, wr_fire, accept_ok;

  // Reset gates ready and writes combinationally so nothing moves in the reset cycle.
  always_comb begin
    accept_ok = !reset && (state_q == StRun) && enable;
    snk_ready = accept_ok && !fifo_full;
    push      = snk_valid && snk_ready;
    wr_fire   = !reset && (state_q != StIdle) && !fifo_empty && mem_grant;
  end

  audio_nios_sample_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (push),
    .wdata_i (snk_data),
    .pop_i   (wr_fire),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Next-state: run control, ring pointer and sticky flags (set beats clear).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (enable) state_d = StRun;
      StRun:   if (!enable) state_d = StDrain;
      StDrain: if (fifo_count == '0) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    wr_ptr_d = wr_ptr_q;
    if (state_q == StIdle && enable) begin
      wr_ptr_d = '0;
    end else if (wr_fire) begin
      wr_ptr_d = (wr_ptr_q == LastIdx) ? '0 : wr_ptr_q + ADDR_W'(1);
    end

    irq_half_d = (wr_fire && wr_ptr_q == HalfIdx) || (irq_half_q && !irq_clear);
    irq_full_d = (wr_fire && wr_ptr_q == LastIdx) || (irq_full_q && !irq_clear);
    overrun_d  = (accept_ok && snk_valid && !snk_ready) || (overrun_q && !irq_clear);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      irq_half_q <= 1'b0;
      irq_full_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      irq_half_q <= irq_half_d;
      irq_full_q <= irq_full_d;
      overrun_q  <= overrun_d;
    end
  end

  // Memory bus drive; the write strobe pair is only raised on a granted write.
  always_comb begin
    mem_address    = BaseAddr + wr_ptr_q;
    mem_byteenable = ByteEnAll;
    mem_chipselect = wr_fire;
    mem_write      = wr_fire;
    mem_writedata  = fifo_rdata;
    mem_clken      = 1'b1;
  end

  assign irq_half = irq_half_q;
  assign irq_full = irq_full_q;
  assign overrun  = overrun_q;
  assign wr_ptr   = wr_ptr_q;

endmodule

// File: tb/tb_audio_nios_sample_writer.sv
// Scoreboard bench: stimulus queues expected {address, data}, a monitor checks each write.
module tb_audio_nios_sample_writer;

  localparam int unsigned Depth = 8;
  localparam int unsigned Base  = 'h40;
  localparam int unsigned AW    = 16;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset, enable, snk_valid, snk_ready, mem_grant, irq_clear;
  logic [31:0]   snk_data, mem_writedata;
  logic [AW-1:0] mem_address, wr_ptr;
  logic [3:0]    mem_byteenable;
  logic          mem_chipselect, mem_write, mem_clken, irq_half, irq_full, overrun;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   exp_idx = 0;
  bit   pend_half = 0;
  bit   pend_full = 0;

  always #5 clk = ~clk;

  audio_nios_sample_writer #(
    .DEPTH_WORDS (Depth),
    .BASE_ADDR   (Base),
    .FIFO_DEPTH  (4),
    .ADDR_W      (AW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .snk_data       (snk_data),
    .snk_valid      (snk_valid),
    .snk_ready      (snk_ready),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_clken      (mem_clken),
    .mem_grant      (mem_grant),
    .irq_half       (irq_half),
    .irq_full       (irq_full),
    .overrun        (overrun),
    .irq_clear      (irq_clear),
    .wr_ptr         (wr_ptr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one sample until accepted; queue its expected ring write.
  task automatic send(input logic [31:0] d);
    bit   done = 0;
    logic r;
    exp_t e;
    snk_valid = 1'b1;
    snk_data  = d;
    for (int n = 0; n < 64 && !done; n++) begin
      @(negedge clk);
      r = snk_ready;
      @(posedge clk);
      #1;
      if (r) begin
        e.a = AW'(Base + exp_idx);
        e.d = d;
        sb.push_back(e);
        exp_idx = (exp_idx + 1) % Depth;
        done = 1;
      end
    end
    snk_valid = 1'b0;
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  // Drain, clear flags, start a fresh run.
  task automatic restart();
    enable = 1'b0;
    mem_grant = 1'b1;
    cyc(6);
    irq_clear = 1'b1;
    cyc(1);
    irq_clear = 1'b0;
    enable = 1'b1;
    exp_idx = 0;
    cyc(2);
    @(negedge clk);
    chk("restart_wr_ptr", 32'(wr_ptr), 32'd0);
    chk("restart_ready", 32'(snk_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare each presented write against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (pend_half) chk("irq_half_after_idx3", 32'(irq_half), 32'd1);
      if (pend_full) chk("irq_full_after_last", 32'(irq_full), 32'd1);
      pend_half = 0;
      pend_full = 0;
      if (mem_write || mem_chipselect) begin
        if (sb.size() == 0) begin
          chk("unexpected_write", 32'(mem_address), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("wr_addr", 32'(mem_address), 32'(e.a));
          chk("wr_data", mem_writedata, e.d);
          chk("wr_strobe_pair", {31'd0, mem_write & mem_chipselect}, 32'd1);
          chk("wr_byteenable", 32'(mem_byteenable), 32'hF);
          if (e.a == AW'(Base + Depth / 2 - 1)) pend_half = 1;
          if (e.a == AW'(Base + Depth - 1)) pend_full = 1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    logic r;
    exp_t e;
    reset = 1'b1; enable = 1'b0; snk_valid = 1'b0; snk_data = '0;
    mem_grant = 1'b1; irq_clear = 1'b0;
    cyc(3);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(snk_ready), 32'd0);
    chk("rst_write", 32'({mem_write, mem_chipselect}), 32'd0);
    chk("rst_wr_ptr", 32'(wr_ptr), 32'd0);
    chk("rst_flags", 32'({irq_half, irq_full, overrun}), 32'd0);
    chk("rst_clken", 32'(mem_clken), 32'd1);

    // Eight samples fill the ring exactly; flags fire at idx 3 and 7.
    @(posedge clk); #1;
    enable = 1'b1;
    exp_idx = 0;
    cyc(2);
    for (int i = 1; i <= 8; i++) send(32'(i));
    cyc(4);
    @(negedge clk);
    chk("fill_wr_ptr", 32'(wr_ptr), 32'd0);
    chk("fill_flags", 32'({irq_half, irq_full}), 32'b11);

    // Ten samples: the last two wrap to ring indices 0 and 1.
    @(posedge clk); #1;
    restart();
    for (int i = 1; i <= 10; i++) send(32'h10 + 32'(i));
    cyc(4);
    @(negedge clk);
    chk("wrap_wr_ptr", 32'(wr_ptr), 32'd2);

    // Stalled grant with continuous valid: only four fit, then overrun.
    @(posedge clk); #1;
    restart();
    mem_grant = 1'b0;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      snk_valid = 1'b1;
      snk_data  = 32'h100 + 32'(i);
      @(negedge clk);
      r = snk_ready;
      @(posedge clk); #1;
      if (r) begin
        e.a = AW'(Base + exp_idx);
        e.d = 32'h100 + 32'(i);
        sb.push_back(e);
        exp_idx = (exp_idx + 1) % Depth;
        acc++;
      end
    end
    snk_valid = 1'b0;
    chk("stall_accepted", 32'(acc), 32'd4);
    @(negedge clk);
    chk("stall_ready", 32'(snk_ready), 32'd0);
    chk("stall_overrun", 32'(overrun), 32'd1);
    @(posedge clk); #1;
    mem_grant = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("burst_write", 32'(mem_write), 32'd1);
    end
    @(negedge clk);
    chk("burst_end", 32'(mem_write), 32'd0);

    // Enable drops with three queued; an enable pulse in drain is ignored.
    @(posedge clk); #1;
    mem_grant = 1'b0;
    for (int i = 0; i < 3; i++) send(32'h200 + 32'(i));
    enable = 1'b0;
    snk_valid = 1'b1;
    snk_data = 32'h2FF;
    @(negedge clk);
    chk("drop_ready", 32'(snk_ready), 32'd0);
    @(posedge clk); #1;
    enable = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("drain_pulse_ready", 32'(snk_ready), 32'd0);
      @(posedge clk); #1;
    end
    enable = 1'b0;
    snk_valid = 1'b0;
    mem_grant = 1'b1;
    cyc(6);
    chk("drain_sb_empty", 32'(sb.size()), 32'd0);
    chk("drain_wr_ptr", 32'(wr_ptr), 32'd7);
    irq_clear = 1'b1;
    cyc(1);
    irq_clear = 1'b0;
    @(negedge clk);
    chk("clear_flags", 32'({irq_half, irq_full, overrun}), 32'd0);
    @(posedge clk); #1;
    enable = 1'b1;
    exp_idx = 0;
    cyc(2);
    @(negedge clk);
    chk("rerun_wr_ptr", 32'(wr_ptr), 32'd0);
    chk("rerun_ready", 32'(snk_ready), 32'd1);
    @(posedge clk); #1;

    // irq_clear coincident with the idx-3 write: the set wins.
    mem_grant = 1'b0;
    for (int i = 0; i < 4; i++) send(32'h300 + 32'(i));
    mem_grant = 1'b1;
    cyc(3);
    irq_clear = 1'b1;
    cyc(1);
    irq_clear = 1'b0;
    @(negedge clk);
    chk("clear_vs_set_half", 32'(irq_half), 32'd1);
    @(posedge clk); #1;
    irq_clear = 1'b1;
    cyc(1);
    irq_clear = 1'b0;
    @(negedge clk);
    chk("clear_half", 32'(irq_half), 32'd0);
    chk("pre_reset_sb_empty", 32'(sb.size()), 32'd0);

    // Reset mid-run with two queued: both are discarded, no write follows.
    @(posedge clk); #1;
    mem_grant = 1'b0;
    send(32'h400);
    send(32'h401);
    reset = 1'b1;
    mem_grant = 1'b1;
    enable = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("reset_cycle_write", 32'({mem_write, mem_chipselect}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_write", 32'({mem_write, mem_chipselect}), 32'd0);
    chk("post_reset_ready", 32'(snk_ready), 32'd0);
    chk("post_reset_wr_ptr", 32'(wr_ptr), 32'd0);
    chk("post_reset_flags", 32'({irq_half, irq_full, overrun}), 32'd0);
    cyc(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/audio_nios_sample_writer.md
AUDIO_NIOS_SAMPLE_WRITER -- requirements
Module: audio_nios_sample_writer

Interface
REQ-001 Parameter DEPTH_WORDS, default 51200, ring-buffer length in 32-bit words.
REQ-002 Parameter BASE_ADDR, default 0, first word address of ring in memory.
REQ-003 Parameter FIFO_DEPTH, default 4, sample FIFO entries (power of 2, at least 2).
REQ-004 Parameter ADDR_W, default 16, memory word-address width.
REQ-005 clk  input  1  single clock, all logic rising-edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 enable  input  1  level; capture run request.
REQ-008 snk_data  input  32  audio sample word (Avalon-ST sink).
REQ-009 snk_valid  input  1  sample present.
REQ-010 snk_ready  output  1  sample accepted when valid&ready at rising edge.
REQ-011 mem_address  output  ADDR_W  word address to on-chip memory.
REQ-012 mem_byteenable  output  4  byte lanes.
REQ-013 mem_chipselect, mem_write  output  1 each  write strobe pair.
REQ-014 mem_writedata  output  32  write data.
REQ-015 mem_clken  output  1  memory clock enable.
REQ-016 mem_grant  input  1  memory port available this cycle (shared with CPU).
REQ-017 irq_half, irq_full  output  1 each  sticky half- and full-ring flags.
REQ-018 overrun  output  1  sticky; sample offered while FIFO full.
REQ-019 irq_clear  input  1  one-cycle pulse clears irq_half, irq_full and overrun.
REQ-020 wr_ptr  output  ADDR_W  ring index of next word to write.

Function
REQ-021 FSM states IDLE, RUN, DRAIN; IDLE->RUN when enable=1; RUN->DRAIN when enable=0; DRAIN->IDLE when FIFO empty and no write in progress.
REQ-022 Entering RUN from IDLE, wr_ptr loads 0.
REQ-023 snk_ready = 1 only in RUN with FIFO not full; 0 in IDLE and DRAIN.
REQ-024 A write cycle occurs when FIFO non-empty and mem_grant=1 (RUN or DRAIN): mem_chipselect=mem_write=1, mem_writedata=FIFO head, mem_address=BASE_ADDR+wr_ptr; FIFO pops and wr_ptr advances at that edge.
REQ-025 Outside write cycles mem_chipselect=mem_write=0; mem_byteenable=4'hF and mem_clken=1 at all times.
REQ-026 Latency: sample accepted at edge N is presented on the memory bus no earlier than the cycle following edge N (earliest write edge N+1); samples are written in acceptance order with no loss or duplication.
REQ-027 Throughput: one write per cycle while mem_grant=1; simultaneous push and pop on a full FIFO are not permitted (ready is low when full); simultaneous push and pop on a non-full FIFO keeps the count unchanged.
REQ-028 wr_ptr wraps from DEPTH_WORDS-1 to 0 on a write.
REQ-029 irq_half sets on the write to index DEPTH_WORDS/2-1; irq_full sets on the write to index DEPTH_WORDS-1.
REQ-030 overrun sets on any RUN cycle with snk_valid=1 and snk_ready=0.
REQ-031 irq_clear clears all three flags; a set condition in the same cycle wins.
REQ-032 enable re-asserted during DRAIN is ignored until IDLE is reached; the next RUN restarts at wr_ptr=0.
REQ-033 mem_grant low stalls writes indefinitely without dropping FIFO contents.
REQ-034 BASE_ADDR+DEPTH_WORDS SHALL not exceed 2**ADDR_W; arithmetic is ADDR_W bits, unsigned.

Reset
REQ-035 reset forces IDLE, FIFO empty, wr_ptr=0, irq_half=irq_full=overrun=0, snk_ready=0, mem_chipselect=mem_write=0.
REQ-036 reset mid-RUN or mid-DRAIN discards FIFO contents; no memory write occurs in the reset cycle or the cycle after.

Structure
REQ-037 Shared package audio_nios_pkg holds the FSM state encoding, data width 32 and byteenable constant 4'hF.
REQ-038 FIFO is a sub-module audio_nios_sample_fifo (synchronous, FIFO_DEPTH entries, full/empty/count outputs).

Verification
REQ-039 DEPTH_WORDS=8, grant=1, 8 samples 0x1..0x8 -> writes to addresses 0..7 in order; irq_half at write 3, irq_full at write 7; wr_ptr=0 afterwards.
REQ-040 10 samples with DEPTH_WORDS=8 -> samples 9 and 10 written to addresses 0 and 1 (wrap).
REQ-041 grant=0 for 10 cycles with continuous valid -> 4 accepted, snk_ready=0, overrun=1; grant=1 -> 4 writes in consecutive cycles, in order.
REQ-042 enable drops with 3 words queued -> snk_ready=0 immediately, 3 writes complete, then IDLE; enable pulse during DRAIN ignored.
REQ-043 irq_clear in the same cycle as the index-3 write (DEPTH_WORDS=8) -> irq_half remains 1.
REQ-044 reset asserted mid-RUN with 2 queued -> no further writes, all outputs at reset values the next cycle.
